// File: rtl/decode_format_arbiter.sv
// Holds one decoded instruction per format decoder and issues one per cycle downstream.
// Build option DECODE_ARB_INORDER_EN: oldest-first (smallest major ID) grant instead of round-robin.
module decode_format_arbiter #(
   parameter int numDecoders             = 4,
   parameter int srcWidth                = 2,
   parameter int instructionCounterWidth = 64,
   parameter int payloadWidth            = 160
) (
   input  logic                                        clock_i,
   input  logic                                        reset_i,
   input  logic [numDecoders-1:0]                      enable_i,
   input  logic [numDecoders*instructionCounterWidth-1:0] majId_i,
   input  logic [numDecoders*payloadWidth-1:0]         payload_i,
   output logic [numDecoders-1:0]                      stall_o,
   input  logic                                        stall_i,
   output logic                                        enable_o,
   output logic [instructionCounterWidth-1:0]          majId_o,
   output logic [payloadWidth-1:0]                     payload_o,
   output logic [srcWidth-1:0]                         src_o,
   output logic [3:0]                                  occupancy_o,
   output logic                                        overflow_o
);

   localparam int idW = instructionCounterWidth;
   localparam int plW = payloadWidth;

   logic [numDecoders-1:0] valid;
   logic [numDecoders-1:0] validNext;
   logic [numDecoders-1:0] capture;
   logic [idW-1:0]         heldMajId   [numDecoders];
   logic [plW-1:0]         heldPayload [numDecoders];
   logic [srcWidth-1:0]    winner;
   logic                   anyValid;
   logic                   doGrant;
   logic [3:0]             occNext;

   assign stall_o = valid;
   assign capture = enable_i & ~valid;
   assign doGrant = anyValid & ~stall_i;

`ifdef DECODE_ARB_INORDER_EN
   logic [idW-1:0] bestId;

   // Strict less-than while scanning upward keeps ties on the lowest index.
   always_comb begin
      anyValid = 1'b0;
      winner   = '0;
      bestId   = '0;
      for (int n = 0; n < numDecoders; n++) begin
         if (valid[n] && (!anyValid || heldMajId[n] < bestId)) begin
            anyValid = 1'b1;
            winner   = srcWidth'(n);
            bestId   = heldMajId[n];
         end
      end
   end
`else
   logic [srcWidth-1:0] rrPtr;
   logic [srcWidth-1:0] nextPtr;

   always_comb begin
      anyValid = 1'b0;
      winner   = '0;
      for (int i = 0; i < numDecoders; i++) begin
         int idx;
         idx = (int'(rrPtr) + i) % numDecoders;
         if (!anyValid && valid[idx]) begin
            anyValid = 1'b1;
            winner   = srcWidth'(idx);
         end
      end
   end

   assign nextPtr = (winner == srcWidth'(numDecoders - 1)) ? '0 : winner + srcWidth'(1);
`endif

   // Capture needs valid=0 and grant needs valid=1, so they never hit the same slot.
   always_comb begin
      validNext = valid | capture;
      if (doGrant) begin
         validNext[winner] = 1'b0;
      end
      occNext = '0;
      for (int n = 0; n < numDecoders; n++) begin
         occNext = occNext + 4'(validNext[n]);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid       <= '0;
         occupancy_o <= '0;
         overflow_o  <= 1'b0;
         enable_o    <= 1'b0;
         majId_o     <= '0;
         payload_o   <= '0;
         src_o       <= '0;
`ifndef DECODE_ARB_INORDER_EN
         rrPtr       <= '0;
`endif
         for (int n = 0; n < numDecoders; n++) begin
            heldMajId[n]   <= '0;
            heldPayload[n] <= '0;
         end
      end else begin
         valid       <= validNext;
         occupancy_o <= occNext;
         enable_o    <= doGrant;
         if (|(enable_i & valid)) begin
            overflow_o <= 1'b1;
         end
         if (doGrant) begin
            majId_o   <= heldMajId[winner];
            payload_o <= heldPayload[winner];
            src_o     <= winner;
`ifndef DECODE_ARB_INORDER_EN
            rrPtr     <= nextPtr;
`endif
         end
         // Decoder 0 owns the most significant slice of the input buses.
         for (int n = 0; n < numDecoders; n++) begin
            if (capture[n]) begin
               heldMajId[n]   <= majId_i[(numDecoders-1-n)*idW +: idW];
               heldPayload[n] <= payload_i[(numDecoders-1-n)*plW +: plW];
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_format_arbiter.sv
// Scoreboard bench for decode_format_arbiter: directed captures, grants, stalls, overflow, reset.
module tb_decode_format_arbiter;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int IW = 64;
   localparam int PW = 160;

   logic            clock_i  = 1'b0;
   logic            reset_i  = 1'b1;
   logic [N-1:0]    enable_i = '0;
   logic [N*IW-1:0] majId_i  = '0;
   logic [N*PW-1:0] payload_i = '0;
   logic            stall_i  = 1'b0;
   logic [N-1:0]    stall_o;
   logic            enable_o;
   logic [IW-1:0]   majId_o;
   logic [PW-1:0]   payload_o;
   logic [SW-1:0]   src_o;
   logic [3:0]      occupancy_o;
   logic            overflow_o;

   decode_format_arbiter #(
      .numDecoders(N), .srcWidth(SW), .instructionCounterWidth(IW), .payloadWidth(PW)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .majId_i(majId_i),
      .payload_i(payload_i), .stall_o(stall_o), .stall_i(stall_i), .enable_o(enable_o),
      .majId_o(majId_o), .payload_o(payload_o), .src_o(src_o),
      .occupancy_o(occupancy_o), .overflow_o(overflow_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [IW-1:0] id;
      logic [PW-1:0] pay;
   } exp_t;

   exp_t sbQ[$];
   exp_t monE;
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [PW-1:0] mkPay(int n, logic [IW-1:0] id);
      return {32'hC0DE0000 + 32'(n), id, ~id};
   endfunction

   task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic setSlot(int n, logic [IW-1:0] id);
      majId_i[(N-1-n)*IW +: IW]   = id;
      payload_i[(N-1-n)*PW +: PW] = mkPay(n, id);
   endtask

   task automatic expectIssue(int n, logic [IW-1:0] id);
      sbQ.push_back('{SW'(n), id, mkPay(n, id)});
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   always @(negedge clock_i) begin
      if (enable_o === 1'b1) begin
         if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual src=%0d majId=%0d required none", src_o, majId_o);
         end else begin
            monE = sbQ.pop_front();
            check("issue_src", PW'(src_o), PW'(monE.src));
            check("issue_majId", PW'(majId_o), PW'(monE.id));
            check("issue_payload", payload_o, monE.pay);
         end
      end
   end

   initial begin
      enable_i = '1;
      setSlot(0, 10); setSlot(1, 11); setSlot(2, 12); setSlot(3, 13);
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      check("rst_enable_o", PW'(enable_o), PW'(0));
      check("rst_majId_o", PW'(majId_o), PW'(0));
      check("rst_payload_o", payload_o, '0);
      check("rst_src_o", PW'(src_o), PW'(0));
      check("rst_stall_o", PW'(stall_o), PW'(0));
      check("rst_occupancy", PW'(occupancy_o), PW'(0));
      check("rst_overflow", PW'(overflow_o), PW'(0));

      // release with all four requesting; round-robin issue 0,1,2,3
      tick();
      reset_i = 1'b0;
      expectIssue(0, 10); expectIssue(1, 11); expectIssue(2, 12); expectIssue(3, 13);
      @(negedge clock_i);
      check("post_rst_occupancy", PW'(occupancy_o), PW'(0));
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("fill_stall_o", PW'(stall_o), PW'(4'b1111));
      check("fill_occupancy", PW'(occupancy_o), PW'(4));
      tick();
      @(negedge clock_i);
      check("rr_first_enable", PW'(enable_o), PW'(1));
      check("rr_first_occupancy", PW'(occupancy_o), PW'(3));
      repeat (4) tick();
      @(negedge clock_i);
      check("rr_drained_enable", PW'(enable_o), PW'(0));
      check("rr_drained_occupancy", PW'(occupancy_o), PW'(0));

      // refill decoders 1 and 3 only
      setSlot(1, 21); setSlot(3, 23);
      enable_i = 4'b1010;
      expectIssue(1, 21); expectIssue(3, 23);
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("refill_stall_o", PW'(stall_o), PW'(4'b1010));
      repeat (3) tick();
      @(negedge clock_i);
      check("refill_drained", PW'(occupancy_o), PW'(0));

      // single request, one-cycle grant latency
      setSlot(2, 7);
      enable_i = 4'b0100;
      expectIssue(2, 7);
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("single_held_stall", PW'(stall_o), PW'(4'b0100));
      check("single_not_yet", PW'(enable_o), PW'(0));
      tick();
      @(negedge clock_i);
      check("single_latency", PW'(enable_o), PW'(1));
      check("single_freed", PW'(stall_o), PW'(0));
      tick();

      // downstream stall holds two entries
      stall_i = 1'b1;
      setSlot(0, 30); setSlot(1, 31);
      enable_i = 4'b0011;
      expectIssue(0, 30); expectIssue(1, 31);
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("stall_occupancy", PW'(occupancy_o), PW'(2));
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clock_i);
         check("stall_no_issue", PW'(enable_o), PW'(0));
         check("stall_hold_occ", PW'(occupancy_o), PW'(2));
      end
      stall_i = 1'b0;
      tick();
      @(negedge clock_i);
      check("unstall_pulse1", PW'(enable_o), PW'(1));
      tick();
      @(negedge clock_i);
      check("unstall_pulse2", PW'(enable_o), PW'(1));
      check("unstall_occ", PW'(occupancy_o), PW'(0));
      tick();

      // overflow: second enable on a held slot is dropped
      stall_i = 1'b1;
      setSlot(0, 40);
      enable_i = 4'b0001;
      expectIssue(0, 40);
      tick();
      @(negedge clock_i);
      check("ovf_before", PW'(overflow_o), PW'(0));
      setSlot(0, 41);
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("ovf_set", PW'(overflow_o), PW'(1));
      check("ovf_occ", PW'(occupancy_o), PW'(1));
      stall_i = 1'b0;
      repeat (3) tick();
      @(negedge clock_i);
      check("ovf_sticky", PW'(overflow_o), PW'(1));

      // asynchronous reset with an entry held
      stall_i = 1'b1;
      setSlot(2, 50);
      enable_i = 4'b0100;
      tick();
      enable_i = '0;
      @(negedge clock_i);
      check("pre_rst_occ", PW'(occupancy_o), PW'(1));
      reset_i = 1'b1;
      #1;
      check("async_rst_occ", PW'(occupancy_o), PW'(0));
      check("async_rst_stall", PW'(stall_o), PW'(0));
      check("async_rst_ovf", PW'(overflow_o), PW'(0));
      tick();
      reset_i = 1'b0;

      // grant order with major IDs {9,3,5,3}
      setSlot(0, 9); setSlot(1, 3); setSlot(2, 5); setSlot(3, 3);
      enable_i = 4'b1111;
`ifdef DECODE_ARB_INORDER_EN
      expectIssue(1, 3); expectIssue(3, 3); expectIssue(2, 5); expectIssue(0, 9);
`else
      expectIssue(0, 9); expectIssue(1, 3); expectIssue(2, 5); expectIssue(3, 3);
`endif
      tick();
      enable_i = '0;
      stall_i  = 1'b0;
      repeat (6) tick();
      @(negedge clock_i);
      check("scoreboard_empty", PW'(sbQ.size()), PW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
